// File: rtl/agu_pipe.sv
// agu_pipe: two-stage pipelined address generation unit.
// Stage 1 forms the raw effective address from the base and immediate/index;
// stage 2 classifies illegal and misaligned accesses and holds the result
// until the downstream stage accepts it. A saturating counter tracks how many
// delivered results carried an exception.
module agu_pipe #(
    parameter int ADDR_W = 32,
    parameter int IMM_W  = 16,
    parameter int OFF_W  = 26,
    parameter int SHAMT  = 2,
    parameter int CNT_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [2:0]        i_opcode,
    input  logic [1:0]        i_size,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [OFF_W-1:0]  i_offset,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [ADDR_W-1:0] o_eff_addr,
    output logic [1:0]        o_exc,
    output logic [CNT_W-1:0]  o_exc_count
);

    localparam logic [2:0] MODE_REG    = 3'b000;
    localparam logic [2:0] MODE_BASE   = 3'b001;
    localparam logic [2:0] MODE_PC_REL = 3'b010;
    localparam logic [2:0] MODE_JUMP   = 3'b011;

    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    // Stage 1 state
    logic              v1;
    logic [2:0]        op1;
    logic [1:0]        size1;
    logic [ADDR_W-1:0] sum1;

    // Combinational helpers
    logic              en1;
    logic              en2;
    logic [ADDR_W-1:0] imm_ext;
    logic [ADDR_W-1:0] jump_idx;
    logic [ADDR_W-1:0] raw_sum;
    logic              legacy_mode;
    logic              illegal;
    logic              misaligned;
    logic [ADDR_W-1:0] addr_next;
    logic [1:0]        exc_next;

    // Stage 2 may advance when empty or draining; stage 1 when stage 2 makes room
    always_comb begin
        en2     = !o_valid || i_ready;
        en1     = !v1 || en2;
        o_ready = en1;
    end

    // Raw effective address for each addressing mode, wrapping modulo 2^ADDR_W
    always_comb begin
        imm_ext  = ADDR_W'($signed(i_offset[IMM_W-1:0]));
        jump_idx = ADDR_W'(i_offset) << SHAMT;
        raw_sum  = '0;
        case (i_opcode)
            MODE_REG:    raw_sum = i_addr;
            MODE_BASE:   raw_sum = i_addr + imm_ext;
            MODE_PC_REL: raw_sum = i_addr + (imm_ext << SHAMT);
            MODE_JUMP:   raw_sum = {i_addr[ADDR_W-1 -: 4], {(ADDR_W-4){1'b0}}} | jump_idx;
            default:     raw_sum = '0;
        endcase
    end

    // Stage 1 register: capture mode, size and raw address; flush drops any input
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v1    <= 1'b0;
            op1   <= '0;
            size1 <= '0;
            sum1  <= '0;
        end else if (i_flush) begin
            v1 <= 1'b0;
        end else if (en1) begin
            v1    <= i_valid;
            op1   <= i_opcode;
            size1 <= i_size;
            sum1  <= raw_sum;
        end
    end

    // Exception classification; register modes honour the access size,
    // branch/jump modes only require the shifted-out bits to be zero
    always_comb begin
        legacy_mode = (op1[2:1] == 2'b00);
        illegal     = op1[2] || (legacy_mode && (size1 == SIZE_RSVD));
        if (legacy_mode) begin
            misaligned = ((size1 == SIZE_HALF) && sum1[0]) ||
                         ((size1 == SIZE_WORD) && (sum1[1:0] != 2'b00));
        end else begin
            misaligned = (sum1[SHAMT-1:0] != '0);
        end
        exc_next  = illegal ? 2'b10 : {1'b0, misaligned};
        addr_next = illegal ? '0 : sum1;
    end

    // Stage 2 register: outputs hold while stalled, flush empties the stage
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid    <= 1'b0;
            o_eff_addr <= '0;
            o_exc      <= '0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
        end else if (en2) begin
            o_valid    <= v1;
            o_eff_addr <= addr_next;
            o_exc      <= exc_next;
        end
    end

    // Count delivered results with an exception; saturates, survives flush
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_exc_count <= '0;
        end else if (o_valid && i_ready && (o_exc != 2'b00) && (o_exc_count != {CNT_W{1'b1}})) begin
            o_exc_count <= o_exc_count + 1'b1;
        end
    end

endmodule

// File: doc/agu_pipe.md
Name: agu_pipe

Overview:
- Parametrised, two-stage pipelined address generation unit. Successor to the single-cycle combinational AGU.
- Computes effective addresses for register-direct, base+offset, PC-relative and pseudo-direct jump modes.
- Adds access-size-aware misalignment detection, illegal-mode detection, a valid/ready handshake with backpressure, flush, and a saturating exception counter.
- Sits between the decode/register-read stage and the memory/branch-resolution stage.

Parameters:
- ADDR_W, 32, address/base width (>= OFF_W+SHAMT+4).
- IMM_W, 16, signed immediate width for modes 001/010.
- OFF_W, 26, jump-index width for mode 011.
- SHAMT, 2, left shift applied to branch/jump offsets.
- CNT_W, 8, exception counter width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_flush  in  1  synchronous pipeline flush.
- i_valid  in  1  upstream request valid.
- o_ready  out  1  AGU can accept the request this cycle.
- i_opcode  in  3  address mode.
- i_size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- i_addr  in  ADDR_W  base (RS value or PC).
- i_offset  in  OFF_W  immediate/index field.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts the result.
- o_eff_addr  out  ADDR_W  effective address.
- o_exc  out  2  bit0 misaligned, bit1 illegal mode/size.
- o_exc_count  out  CNT_W  saturating count of delivered results with o_exc != 0.

Behaviour:
- Reset (async, i_rst_n=0): both stage valids=0, o_valid=0, o_eff_addr=0, o_exc=0, o_exc_count=0. Reset asserted mid-operation discards in-flight requests immediately.
- Handshake:
  - Transfer in when i_valid && o_ready.
  - Transfer out when o_valid && i_ready.
  - o_eff_addr/o_exc hold stable while o_valid && !i_ready.
- Enables:
  - en2 = !v2 || i_ready.
  - en1 = !v1 || en2.
  - o_ready = en1 (combinational from i_ready).
- Full throughput of 1 request/cycle. Latency is 2 cycles from accept to o_valid when there is no stall.
- Stage 1 (on en1): register the mode, size and raw sum.
  - 000: addr = i_addr.
  - 001: addr = i_addr + sext(i_offset[IMM_W-1:0]).
  - 010: addr = i_addr + (sext(i_offset[IMM_W-1:0]) << SHAMT).
  - 011: addr = {i_addr[ADDR_W-1:ADDR_W-4], zero-padding, i_offset, SHAMT zeros}, where the zero-padding is ADDR_W-4-OFF_W-SHAMT bits (0 at defaults).
  - 100-111: illegal; addr = 0.
  - All sums are modulo 2^ADDR_W; carry is discarded, with no overflow flag.
- Stage 2 (on en2): compute exceptions and register the outputs.
  - Illegal (bit1) is set for opcode >= 100, or for i_size = 11 in modes 000/001. When illegal, bit0 = 0 and addr = 0.
  - Misalignment (bit0), modes 000/001: set for half with addr[0]=1, or word with addr[1:0] != 0. Byte accesses never set it.
  - Misalignment (bit0), modes 010/011: set for addr[SHAMT-1:0] != 0. i_size is ignored.
- Exception counter: increments by 1 on each output transfer with o_exc != 0. It saturates at 2^CNT_W-1 and is not cleared by flush.
- Flush (i_flush=1 at a clock edge):
  - Clears v1 and v2, so o_valid=0 next cycle.
  - An input presented in the same cycle is dropped.
  - A result handshaked in the same cycle counts as delivered.
  - Flush has priority over all enables.
- Simultaneous in/out transfers with both stages full: the pipeline shifts, with no bubble and no loss.

Test Plan:
- Reset then mode 001: i_addr=0x0000_1000, offset=0xFFFC (-4), size=10 -> 2 cycles later o_eff_addr=0x0000_0FFC, o_exc=00, o_valid=1.
- Misalignment: mode 001, i_addr=0x2001, offset=0, size=01 -> o_exc=01. Same with size=00 -> o_exc=00. Mode 000, addr=0x2002, size=10 -> o_exc=01. o_exc_count=2.
- Branch/jump: mode 010, i_addr=0x0040_0000, offset=0x0003 -> 0x0040_000C. Mode 011, i_addr=0xA000_0000, offset=0x0000100 -> 0xA000_0400. Mode 110 -> o_eff_addr=0, o_exc=10.
- Backpressure: stream 5 requests with i_ready held 0 for 4 cycles -> o_ready drops after 2 accepts, outputs stay stable, all 5 results appear in order with no duplicates or loss.
- Flush: 2 requests in flight, assert i_flush one cycle -> o_valid=0 next cycle, flushed results never appear, and the next request returns after 2 cycles.
- Async reset mid-stream plus counter saturation (CNT_W=2, 5 exceptions) -> outputs zero immediately on reset. In a separate run, o_exc_count sticks at 3.
